// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM: memory wait-states, iterative mult/div sequencing
// and precise exceptions through EPC. All datapath controls are registered Moore outputs.
module mc_control_unit #(
    parameter int MEM_WAIT  = 2,
    parameter int MD_CYCLES = 32,
    parameter int EXC_BASE  = 253
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        overflow,
    input  logic        div_zero,
    output logic        pc_write,
    output logic [1:0]  pc_cond,
    output logic [2:0]  pc_src,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_wr,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst_sel,
    output logic [2:0]  wdata_sel,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  alu_op,
    output logic        aluout_write,
    output logic        epc_write,
    output logic        md_start,
    output logic        md_op,
    output logic        hilo_write,
    output logic [4:0]  state_dbg,
    output logic [31:0] exc_vec_addr
);

    localparam logic [5:0] MEM_LAST = 6'(MEM_WAIT);
    localparam logic [5:0] MD_LAST  = 6'(MD_CYCLES - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EXEC_R   = 5'd3,
        S_EXEC_I   = 5'd4,
        S_ALU_WB   = 5'd5,
        S_LUI_WB   = 5'd6,
        S_ADDR     = 5'd7,
        S_MEM_RD   = 5'd8,
        S_LOAD_WB  = 5'd9,
        S_STORE    = 5'd10,
        S_BRANCH   = 5'd11,
        S_JUMP     = 5'd12,
        S_JAL      = 5'd13,
        S_JR       = 5'd14,
        S_MD_START = 5'd15,
        S_MD_RUN   = 5'd16,
        S_MD_WB    = 5'd17,
        S_MFHI_WB  = 5'd18,
        S_MFLO_WB  = 5'd19,
        S_EXC_EPC  = 5'd20,
        S_EXC_RD   = 5'd21,
        S_EXC_PC   = 5'd22
    } state_e;

    typedef enum logic [4:0] {
        I_ADD, I_SUB, I_AND, I_SLT, I_ADDI, I_LUI, I_LW, I_SW, I_BEQ, I_BNE,
        I_J, I_JAL, I_JR, I_MULT, I_DIV, I_MFHI, I_MFLO, I_BAD
    } instr_e;

    typedef enum logic [1:0] {
        EXC_OPCODE = 2'd0,
        EXC_OVF    = 2'd1,
        EXC_DIV0   = 2'd2
    } exc_e;

    typedef struct packed {
        logic        pc_write;
        logic [1:0]  pc_cond;
        logic [2:0]  pc_src;
        logic [1:0]  mem_addr_sel;
        logic        mem_wr;
        logic        ir_write;
        logic        reg_write;
        logic [1:0]  reg_dst_sel;
        logic [2:0]  wdata_sel;
        logic [1:0]  alu_a_sel;
        logic [1:0]  alu_b_sel;
        logic [2:0]  alu_op;
        logic        aluout_write;
        logic        epc_write;
        logic        md_start;
        logic        md_op;
        logic        hilo_write;
        logic [31:0] exc_vec_addr;
    } ctrl_t;

    state_e state_q, state_d;
    instr_e instr_q, instr_d;
    exc_e   exc_q, exc_d;
    logic [5:0] cnt_q, cnt_d;
    ctrl_t  ctrl_q, ctrl_d;

    function automatic instr_e decode(input logic [5:0] op, input logic [5:0] fn);
        instr_e i;
        i = I_BAD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  i = I_ADD;
                    FN_SUB:  i = I_SUB;
                    FN_AND:  i = I_AND;
                    FN_SLT:  i = I_SLT;
                    FN_JR:   i = I_JR;
                    FN_MULT: i = I_MULT;
                    FN_DIV:  i = I_DIV;
                    FN_MFHI: i = I_MFHI;
                    FN_MFLO: i = I_MFLO;
                    default: i = I_BAD;
                endcase
            end
            OP_ADDI: i = I_ADDI;
            OP_LUI:  i = I_LUI;
            OP_LW:   i = I_LW;
            OP_SW:   i = I_SW;
            OP_BEQ:  i = I_BEQ;
            OP_BNE:  i = I_BNE;
            OP_J:    i = I_J;
            OP_JAL:  i = I_JAL;
            default: i = I_BAD;
        endcase
        return i;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        cnt_d   = cnt_q + 6'd1;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (cnt_q == MEM_LAST) state_d = S_DECODE;
            S_DECODE: begin
                instr_d = decode(opcode, funct);
                case (instr_d)
                    I_ADD, I_SUB, I_AND, I_SLT: state_d = S_EXEC_R;
                    I_ADDI:                     state_d = S_EXEC_I;
                    I_LUI:                      state_d = S_LUI_WB;
                    I_LW, I_SW:                 state_d = S_ADDR;
                    I_BEQ, I_BNE:               state_d = S_BRANCH;
                    I_J:                        state_d = S_JUMP;
                    I_JAL:                      state_d = S_JAL;
                    I_JR:                       state_d = S_JR;
                    I_MULT, I_DIV:              state_d = S_MD_START;
                    I_MFHI:                     state_d = S_MFHI_WB;
                    I_MFLO:                     state_d = S_MFLO_WB;
                    default: begin
                        state_d = S_EXC_EPC;
                        exc_d   = EXC_OPCODE;
                    end
                endcase
            end
            S_EXEC_R: begin
                if (overflow && (instr_q == I_ADD || instr_q == I_SUB)) begin
                    state_d = S_EXC_EPC;
                    exc_d   = EXC_OVF;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_EXEC_I: begin
                if (overflow) begin
                    state_d = S_EXC_EPC;
                    exc_d   = EXC_OVF;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_ADDR:   state_d = (instr_q == I_LW) ? S_MEM_RD : S_STORE;
            S_MEM_RD: if (cnt_q == MEM_LAST) state_d = S_LOAD_WB;
            S_MD_START: begin
                if (instr_q == I_DIV && div_zero) begin
                    state_d = S_EXC_EPC;
                    exc_d   = EXC_DIV0;
                end else begin
                    state_d = S_MD_RUN;
                end
            end
            S_MD_RUN:  if (cnt_q == MD_LAST) state_d = S_MD_WB;
            S_EXC_EPC: state_d = S_EXC_RD;
            S_EXC_RD:  if (cnt_q == MEM_LAST) state_d = S_EXC_PC;
            S_ALU_WB, S_LUI_WB, S_LOAD_WB, S_STORE, S_BRANCH, S_JUMP, S_JAL, S_JR,
            S_MD_WB, S_MFHI_WB, S_MFLO_WB, S_EXC_PC: state_d = S_FETCH;
            default:   state_d = S_RESET;
        endcase
        // Wait/iteration counter restarts on every state entry.
        if (state_d != state_q) cnt_d = '0;
    end

    // Controls are decoded from the next state so they register in step with state_q.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.alu_b_sel = 2'd1;
                ctrl_d.alu_op    = ALU_ADD;
                if (cnt_d == MEM_LAST) begin
                    ctrl_d.ir_write = 1'b1;
                    ctrl_d.pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl_d.alu_b_sel    = 2'd3;
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_d.alu_a_sel    = 2'd1;
                ctrl_d.aluout_write = 1'b1;
                case (instr_d)
                    I_SUB:   ctrl_d.alu_op = ALU_SUB;
                    I_AND:   ctrl_d.alu_op = ALU_AND;
                    I_SLT:   ctrl_d.alu_op = ALU_SLT;
                    default: ctrl_d.alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_I, S_ADDR: begin
                ctrl_d.alu_a_sel    = 2'd1;
                ctrl_d.alu_b_sel    = 2'd2;
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.aluout_write = 1'b1;
            end
            S_ALU_WB: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.reg_dst_sel = (instr_d == I_ADDI) ? 2'd0 : 2'd1;
            end
            S_LUI_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.wdata_sel = 3'd4;
            end
            S_MEM_RD: ctrl_d.mem_addr_sel = 2'd1;
            S_LOAD_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.wdata_sel = 3'd1;
            end
            S_STORE: begin
                ctrl_d.mem_addr_sel = 2'd1;
                ctrl_d.mem_wr       = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_a_sel = 2'd1;
                ctrl_d.alu_op    = ALU_SUB;
                ctrl_d.pc_src    = 3'd1;
                ctrl_d.pc_cond   = (instr_d == I_BNE) ? 2'd2 : 2'd1;
            end
            S_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 3'd2;
            end
            S_JAL: begin
                ctrl_d.pc_write    = 1'b1;
                ctrl_d.pc_src      = 3'd2;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.reg_dst_sel = 2'd2;
                ctrl_d.wdata_sel   = 3'd5;
            end
            S_JR: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 3'd3;
            end
            S_MD_START: begin
                ctrl_d.md_start = 1'b1;
                ctrl_d.md_op    = (instr_d == I_DIV);
            end
            S_MD_WB: ctrl_d.hilo_write = 1'b1;
            S_MFHI_WB, S_MFLO_WB: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.reg_dst_sel = 2'd1;
                ctrl_d.wdata_sel   = (state_d == S_MFHI_WB) ? 3'd2 : 3'd3;
            end
            S_EXC_EPC: begin
                ctrl_d.epc_write = 1'b1;
                ctrl_d.alu_b_sel = 2'd1;
                ctrl_d.alu_op    = ALU_SUB;
            end
            S_EXC_RD: begin
                ctrl_d.mem_addr_sel = 2'd2;
                ctrl_d.exc_vec_addr = 32'(EXC_BASE) + 32'(exc_d);
            end
            S_EXC_PC: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = 3'd4;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= S_RESET;
            instr_q <= I_BAD;
            exc_q   <= EXC_OPCODE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pc_write     = ctrl_q.pc_write;
    assign pc_cond      = ctrl_q.pc_cond;
    assign pc_src       = ctrl_q.pc_src;
    assign mem_addr_sel = ctrl_q.mem_addr_sel;
    assign mem_wr       = ctrl_q.mem_wr;
    assign ir_write     = ctrl_q.ir_write;
    assign reg_write    = ctrl_q.reg_write;
    assign reg_dst_sel  = ctrl_q.reg_dst_sel;
    assign wdata_sel    = ctrl_q.wdata_sel;
    assign alu_a_sel    = ctrl_q.alu_a_sel;
    assign alu_b_sel    = ctrl_q.alu_b_sel;
    assign alu_op       = ctrl_q.alu_op;
    assign aluout_write = ctrl_q.aluout_write;
    assign epc_write    = ctrl_q.epc_write;
    assign md_start     = ctrl_q.md_start;
    assign md_op        = ctrl_q.md_op;
    assign hilo_write   = ctrl_q.hilo_write;
    assign exc_vec_addr = ctrl_q.exc_vec_addr;
    assign state_dbg    = state_q;

endmodule
